// File: rtl/irq_controller4_pkg.sv
// Shared constants and types for the four-source interrupt controller.
// Holds the controller state encoding and the source count.
package irq_controller4_pkg;

   localparam int NUM_IRQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/priorityEncoder4bit.sv
// Four-input priority encoder, bit 3 highest priority.
// Ports: i (requests), enable, out = {valid, index[1:0]}.
module priorityEncoder4bit (
   input  logic [3:0] i,
   input  logic       enable,
   output logic [2:0] out
);

   always_comb begin
      out = 3'b000;
      if (enable) begin
         if (i[3])
            out = 3'b111;
         else if (i[2])
            out = 3'b110;
         else if (i[1])
            out = 3'b101;
         else if (i[0])
            out = 3'b100;
      end
   end

endmodule

// File: rtl/irq_controller4.sv
// Four-source edge-triggered interrupt controller with mask,
// priority arbitration and ack / end-of-interrupt handshakes.
// Ports: clk, reset (sync, active-high), enable, req[3:0],
//   mask_wr, mask_in[3:0], ack, eoi -> irq, irq_id[1:0],
//   in_service, pending[3:0], mask[3:0].
module irq_controller4
   import irq_controller4_pkg::*;
#(
   parameter logic [NUM_IRQ-1:0] MASK_RESET = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_IRQ-1:0] req,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_in,
   input  logic               ack,
   input  logic               eoi,
   output logic               irq,
   output logic [1:0]         irq_id,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask
);

   state_t             state;
   logic [NUM_IRQ-1:0] req_q;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] enc_in;
   logic [2:0]         enc;

   assign rise   = req & ~req_q;
   assign enc_in = pending & ~mask;

   priorityEncoder4bit u_enc (
      .i      (enc_in),
      .enable (enable),
      .out    (enc)
   );

   // Acknowledge retires only the source being serviced.
   always_comb begin
      clr = '0;
      if (state == ST_ASSERT && ack)
         clr[irq_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_q   <= '0;
         pending <= '0;
         mask    <= MASK_RESET;
      end else begin
         req_q   <= req;
         // A fresh edge wins over a same-cycle clear.
         pending <= (pending & ~clr) | rise;
         if (mask_wr)
            mask <= mask_in;
      end
   end

   // Once asserted, a request is held until ack even if it
   // gets masked or enable drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         irq        <= 1'b0;
         irq_id     <= 2'd0;
         in_service <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (enc[2]) begin
                  irq_id <= enc[1:0];
                  irq    <= 1'b1;
                  state  <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (ack) begin
                  irq        <= 1'b0;
                  in_service <= 1'b1;
                  state      <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (eoi) begin
                  in_service <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               irq        <= 1'b0;
               in_service <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller4.sv
// Self-checking bench for irq_controller4: directed plan plus
// randomized traffic checked against a behavioural model.
module tb_irq_controller4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] req;
   logic       mask_wr;
   logic [3:0] mask_in;
   logic       ack;
   logic       eoi;
   logic       irq;
   logic [1:0] irq_id;
   logic       in_service;
   logic [3:0] pending;
   logic [3:0] mask;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 = waiting, 1 = raised, 2 = being serviced.
   int         m_phase;
   int         m_id;
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   logic [3:0] m_prev;

   irq_controller4 dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req        (req),
      .mask_wr    (mask_wr),
      .mask_in    (mask_in),
      .ack        (ack),
      .eoi        (eoi),
      .irq        (irq),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending),
      .mask       (mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input int unsigned got,
                      input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int top_bit(input logic [3:0] v);
      for (int k = 3; k >= 0; k--)
         if (v[k]) return k;
      return -1;
   endfunction

   task automatic model_step();
      logic [3:0] rise;
      logic [3:0] clr;
      logic [3:0] avail;
      if (reset) begin
         m_phase = 0;
         m_id    = 0;
         m_pend  = 4'h0;
         m_mask  = 4'hF;
         m_prev  = 4'h0;
      end else begin
         rise  = req & ~m_prev;
         clr   = 4'h0;
         avail = m_pend & ~m_mask;
         if (m_phase == 0) begin
            if (enable && avail != 0) begin
               m_id    = top_bit(avail);
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ack) begin
               clr     = 4'(1 << m_id);
               m_phase = 2;
            end
         end else if (eoi) begin
            m_phase = 0;
         end
         m_pend = (m_pend & ~clr) | rise;
         if (mask_wr) m_mask = mask_in;
         m_prev = req;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("m_irq", irq, (m_phase == 1) ? 1 : 0);
      chk("m_in_service", in_service, (m_phase == 2) ? 1 : 0);
      chk("m_irq_id", irq_id, m_id);
      chk("m_pending", pending, m_pend);
      chk("m_mask", mask, m_mask);
   endtask

   initial begin
      m_phase = 0; m_id = 0;
      m_pend = 0; m_mask = 4'hF; m_prev = 0;
      reset = 1; enable = 0; req = 0;
      mask_wr = 0; mask_in = 0; ack = 0; eoi = 0;
      #2;
      cyc(); cyc();
      reset = 0;
      chk("rst_irq", irq, 0);
      chk("rst_pending", pending, 0);
      chk("rst_mask", mask, 4'hF);
      chk("rst_in_service", in_service, 0);
      mask_wr = 1; mask_in = 4'h0; enable = 1;
      cyc();
      mask_wr = 0;

      // single source
      req = 4'b0010; cyc();
      chk("single_pend", pending, 4'b0010);
      req = 4'b0000; cyc();
      chk("single_irq", irq, 1);
      chk("single_id", irq_id, 1);
      ack = 1; cyc(); ack = 0;
      chk("single_clr", pending, 0);
      chk("single_svc", in_service, 1);
      eoi = 1; cyc(); eoi = 0;
      cyc();
      chk("single_eoi_irq", irq, 0);

      // priority
      req = 4'b0101; cyc();
      req = 4'b0000; cyc();
      chk("prio_first", irq_id, 2);
      ack = 1; cyc(); ack = 0;
      eoi = 1; cyc(); eoi = 0;
      chk("prio_gap", irq, 0);
      cyc();
      chk("prio_second_irq", irq, 1);
      chk("prio_second_id", irq_id, 0);
      ack = 1; cyc(); ack = 0;
      chk("prio_pend_done", pending, 0);
      eoi = 1; cyc(); eoi = 0;

      // masking
      mask_wr = 1; mask_in = 4'b0100; cyc(); mask_wr = 0;
      req = 4'b0100; cyc();
      req = 4'b0000; cyc();
      chk("mask_pend", pending, 4'b0100);
      chk("mask_noirq", irq, 0);
      mask_wr = 1; mask_in = 4'b0000; cyc(); mask_wr = 0;
      cyc();
      chk("unmask_irq", irq, 1);
      chk("unmask_id", irq_id, 2);
      ack = 1; cyc(); ack = 0;
      eoi = 1; cyc(); eoi = 0;

      // enable gating and held request
      enable = 0; req = 4'b1000; cyc(); cyc();
      chk("en_pend", pending, 4'b1000);
      chk("en_noirq", irq, 0);
      enable = 1; cyc();
      chk("en_irq_id", irq_id, 3);
      ack = 1; cyc(); ack = 0;
      cyc(); cyc();
      chk("held_no_edge", pending, 0);
      eoi = 1; cyc(); eoi = 0;
      cyc(); cyc();
      chk("held_no_irq", irq, 0);
      req = 4'b0000; cyc();

      // re-rise in the same cycle as its ack
      req = 4'b0100; cyc();
      req = 4'b0000; cyc();
      chk("rerise_irq", irq, 1);
      req = 4'b0100; ack = 1; cyc();
      req = 4'b0000; ack = 0;
      chk("rerise_pend", pending[2], 1);
      eoi = 1; cyc(); eoi = 0;
      cyc();
      ack = 1; cyc(); ack = 0;
      eoi = 1; cyc(); eoi = 0;

      // reset while servicing
      req = 4'b0001; cyc();
      req = 4'b0000; cyc();
      ack = 1; cyc(); ack = 0;
      chk("pre_rst_svc", in_service, 1);
      reset = 1; cyc(); reset = 0;
      chk("svc_rst_irq", irq, 0);
      chk("svc_rst_svc", in_service, 0);
      chk("svc_rst_id", irq_id, 0);
      chk("svc_rst_pend", pending, 0);
      chk("svc_rst_mask", mask, 4'hF);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         reset   = ($urandom_range(0, 99) == 0);
         enable  = ($urandom_range(0, 9) != 0);
         req     = 4'($urandom);
         mask_wr = ($urandom_range(0, 7) == 0);
         mask_in = 4'($urandom) & 4'($urandom);
         ack     = ($urandom_range(0, 2) == 0);
         eoi     = ($urandom_range(0, 2) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
